lc3b_fetch_unit: RTL

//  Parametrised next-generation PC/fetch front end. Holds the fetch PC, computes redirect targets:
//  PC-relative offset9/offset11, ALU register target, memory-loaded target.

---
 rtl/lc3b_fetch_unit_pkg.sv | 24 ++
 rtl/lc3b_fetch_unit_queue.sv | 51 +++++
 rtl/lc3b_fetch_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/lc3b_fetch_unit_pkg.sv
// Shared types for the LC-3b fetch front end: redirect selector, FSM state, queue entry.
package lc3b_fetch_unit_pkg;

   localparam int LC3B_WIDTH = 16;

   typedef enum logic [1:0] {
      BR9   = 2'd0,
      JSR11 = 2'd1,
      ALU   = 2'd2,
      MEM   = 2'd3
   } lc3b_redir_sel;

   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

   // Base-width entry layout; the queue stores the same {pc,instr} order at any WIDTH.
   typedef struct packed {
      logic [LC3B_WIDTH-1:0] pc;
      logic [LC3B_WIDTH-1:0] instr;
   } lc3b_fetch_entry;

endpackage

// File: rtl/lc3b_fetch_unit_queue.sv
// DEPTH-entry synchronous prefetch FIFO holding {pc,instr} pairs; flush empties it in one cycle.
module lc3b_fetch_queue #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_pc,
   input  logic [WIDTH-1:0]         push_instr,
   input  logic                     pop,
   output logic                     head_valid,
   output logic [WIDTH-1:0]         head_pc,
   output logic [WIDTH-1:0]         head_instr,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [2*WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic               do_push, do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && (count != CW'(DEPTH));

   assign head_valid = (count != '0);
   assign {head_pc, head_instr} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {push_pc, push_instr};
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/lc3b_fetch_unit.sv
// LC-3b fetch front end: PC register, redirect target adders, single-outstanding imem FSM, prefetch queue.
// Define FETCH_BYPASS_EN to forward a response straight to the head outputs when the queue is empty.
module lc3b_fetch_unit
   import lc3b_fetch_unit_pkg::*;
#(
   parameter int               WIDTH    = 16,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_read,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_resp,
   input  logic [WIDTH-1:0] imem_rdata,
   input  logic             redir_valid,
   input  logic [1:0]       redir_sel,
   input  logic [WIDTH-1:0] redir_base_pc,
   input  logic [8:0]       redir_offset9,
   input  logic [10:0]      redir_offset11,
   input  logic [WIDTH-1:0] redir_alu,
   input  logic [WIDTH-1:0] redir_mem,
   output logic             instr_valid,
   output logic [WIDTH-1:0] instr,
   output logic [WIDTH-1:0] instr_pc,
   input  logic             instr_ready,
   output logic [WIDTH-1:0] pc_out
);
   localparam int               CW  = $clog2(DEPTH) + 1;
   localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   fetch_state_e     state, state_nx;
   logic [WIDTH-1:0] pc, pc_nx, drain_addr, target;
   logic [CW-1:0]    count;
   logic             q_valid;
   logic [WIDTH-1:0] q_pc, q_instr;
   logic             fetching, accept, byp, push, pop;

   always_comb begin
      target = redir_base_pc;
      unique case (lc3b_redir_sel'(redir_sel))
         BR9:   target = redir_base_pc + TWO +
                         {{(WIDTH-10){redir_offset9[8]}}, redir_offset9, 1'b0};
         JSR11: target = redir_base_pc + TWO +
                         {{(WIDTH-12){redir_offset11[10]}}, redir_offset11, 1'b0};
         ALU:   target = redir_alu & ~ONE;
         MEM:   target = redir_mem & ~ONE;
         default: target = redir_base_pc;
      endcase
   end

   // Count only rises on a push, which needs a response, so the request stays up once raised.
   assign fetching  = (state == FETCH) && (count < CW'(DEPTH));
   assign imem_read = !reset && ((state == DRAIN) || fetching);
   assign imem_addr = (state == DRAIN) ? drain_addr : pc;
   assign accept    = (state == FETCH) && imem_resp && !redir_valid;

`ifdef FETCH_BYPASS_EN
   assign byp = accept && (count == '0);
`else
   assign byp = 1'b0;
`endif

   assign instr_valid = q_valid || byp;
   assign instr       = q_valid ? q_instr : imem_rdata;
   assign instr_pc    = q_valid ? q_pc    : pc;
   assign pc_out      = pc;

   assign pop  = instr_ready && q_valid && !redir_valid;
   assign push = accept && !(byp && instr_ready);

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      if (redir_valid) begin
         pc_nx = target;
         if (fetching && !imem_resp)
            state_nx = DRAIN;
         else if (state == DRAIN && imem_resp)
            state_nx = FETCH;
      end else begin
         if (accept) pc_nx = pc + TWO;
         if (state == DRAIN && imem_resp) state_nx = FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         drain_addr <= RESET_PC;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         // Keep presenting the abandoned address until memory answers it.
         if (state == FETCH && state_nx == DRAIN) drain_addr <= pc;
      end
   end

   lc3b_fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .reset      (reset),
      .flush      (redir_valid),
      .push       (push),
      .push_pc    (pc),
      .push_instr (imem_rdata),
      .pop        (pop),
      .head_valid (q_valid),
      .head_pc    (q_pc),
      .head_instr (q_instr),
      .count      (count)
   );

endmodule
